pattern_scan: RTL

- Hardware responder for the program-3 request/ack flow: on a `start` pulse it reads the 5-bit pattern and a 32-byte message from data memory.
- It computes three match counts and writes them back to data memory, then raises `done`.
- Sits beside the data memory as an alternate memory master. It implements the same result layout the program-3 bench checks, in fixed-function hardware.

---
 rtl/pattern_scan_pkg.sv | 18 +
 rtl/pattern_window_match.sv | 28 ++
 rtl/pattern_scan.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/pattern_scan_pkg.sv
// Shared types and constants for the pattern scanner.
package pattern_scan_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_PAT,
        SCAN,
        WR_CTB,
        WR_CTO,
        WR_CTS,
        DONE
    } state_t;

    localparam int PAT_ADDR_DEF = 32;
    localparam int RES_ADDR_DEF = 33;
    localparam int CNT_W        = 8;

endpackage

// File: rtl/pattern_window_match.sv
// Counts 5-bit pattern hits for one message byte: four in-byte windows and,
// unless this is the first byte, four windows straddling the previous byte's low nibble.
module pattern_window_match (
    input  logic [4:0] pat,
    input  logic [3:0] prev_nib,
    input  logic [7:0] cur,
    input  logic       first,
    output logic [2:0] in_cnt,
    output logic       any_hit,
    output logic [2:0] cross_cnt
);

    logic [11:0] s;

    // s[j +: 5] for j=0..3 lies inside cur; j=4..7 straddles prev_nib and cur.
    always_comb begin
        s         = {prev_nib, cur};
        in_cnt    = '0;
        cross_cnt = '0;
        for (int j = 0; j < 4; j++) begin
            if (s[j +: 5] == pat) in_cnt = in_cnt + 3'd1;
            if (!first && (s[j + 4 +: 5] == pat)) cross_cnt = cross_cnt + 3'd1;
        end
    end

    assign any_hit = (in_cnt != 3'd0);

endmodule

// File: rtl/pattern_scan.sv
// Memory-mastered pattern scanner: loads pattern + NUM_BYTES message bytes, writes ctb/cto/cts, raises done.
// Define PATSCAN_SYNC_RD_EN for a one-cycle-latency memory read (adds one cycle of latency).
module pattern_scan
    import pattern_scan_pkg::*;
#(
    parameter int NUM_BYTES = 32,
    parameter int PAT_ADDR  = PAT_ADDR_DEF,
    parameter int RES_ADDR  = RES_ADDR_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       done,
    output logic [7:0] mem_addr,
    input  logic [7:0] mem_rd_data,
    output logic       mem_wr_en,
    output logic [7:0] mem_wr_data
);

    localparam logic [7:0] LAST_IDX = 8'(NUM_BYTES - 1);

    state_t           state_q, state_d;
    logic [4:0]       pat_q, pat_d;
    logic [3:0]       prev_q, prev_d;
    logic [7:0]       idx_q, idx_d;
    logic [CNT_W-1:0] ctb_q, ctb_d, cto_q, cto_d, cts_q, cts_d;
    logic             done_q, done_d;
    logic             take;
    logic [2:0]       in_cnt, cross_cnt;
    logic             any_hit;
`ifdef PATSCAN_SYNC_RD_EN
    logic             ld_ph_q, ld_ph_d, vld_q, vld_d;
`endif

    pattern_window_match u_match (
        .pat       (pat_q),
        .prev_nib  (prev_q),
        .cur       (mem_rd_data),
        .first     (idx_q == 8'd0),
        .in_cnt    (in_cnt),
        .any_hit   (any_hit),
        .cross_cnt (cross_cnt)
    );

    assign done = done_q;

    always_comb begin
        state_d     = state_q;
        pat_d       = pat_q;
        prev_d      = prev_q;
        idx_d       = idx_q;
        ctb_d       = ctb_q;
        cto_d       = cto_q;
        cts_d       = cts_q;
        done_d      = 1'b0;
        take        = 1'b0;
        mem_addr    = 8'd0;
        mem_wr_en   = 1'b0;
        mem_wr_data = 8'd0;
`ifdef PATSCAN_SYNC_RD_EN
        ld_ph_d     = ld_ph_q;
        vld_d       = 1'b0;
`endif
        case (state_q)
            IDLE, DONE: begin
                done_d = (state_q == DONE);
                if (start) begin
                    state_d = LOAD_PAT;
                    done_d  = 1'b0;
                    ctb_d   = '0;
                    cto_d   = '0;
                    cts_d   = '0;
                    prev_d  = '0;
                    idx_d   = '0;
`ifdef PATSCAN_SYNC_RD_EN
                    ld_ph_d = 1'b0;
`endif
                end
            end
            LOAD_PAT: begin
`ifdef PATSCAN_SYNC_RD_EN
                // Second phase captures the pattern and already issues byte 0.
                if (!ld_ph_q) begin
                    mem_addr = 8'(PAT_ADDR);
                    ld_ph_d  = 1'b1;
                end else begin
                    mem_addr = 8'd0;
                    pat_d    = mem_rd_data[7:3];
                    vld_d    = 1'b1;
                    idx_d    = '0;
                    state_d  = SCAN;
                end
`else
                mem_addr = 8'(PAT_ADDR);
                pat_d    = mem_rd_data[7:3];
                idx_d    = '0;
                state_d  = SCAN;
`endif
            end
            SCAN: begin
`ifdef PATSCAN_SYNC_RD_EN
                mem_addr = idx_q + 8'd1;
                vld_d    = (idx_q != LAST_IDX);
                take     = vld_q;
`else
                mem_addr = idx_q;
                take     = 1'b1;
`endif
                if (take) begin
                    ctb_d  = ctb_q + CNT_W'(in_cnt);
                    cto_d  = cto_q + CNT_W'(any_hit);
                    cts_d  = cts_q + CNT_W'(in_cnt) + CNT_W'(cross_cnt);
                    prev_d = mem_rd_data[3:0];
                    if (idx_q == LAST_IDX) state_d = WR_CTB;
                    else                   idx_d   = idx_q + 8'd1;
                end
            end
            WR_CTB: begin
                mem_addr    = 8'(RES_ADDR);
                mem_wr_en   = 1'b1;
                mem_wr_data = ctb_q;
                state_d     = WR_CTO;
            end
            WR_CTO: begin
                mem_addr    = 8'(RES_ADDR + 1);
                mem_wr_en   = 1'b1;
                mem_wr_data = cto_q;
                state_d     = WR_CTS;
            end
            WR_CTS: begin
                mem_addr    = 8'(RES_ADDR + 2);
                mem_wr_en   = 1'b1;
                mem_wr_data = cts_q;
                state_d     = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pat_q   <= '0;
            prev_q  <= '0;
            idx_q   <= '0;
            ctb_q   <= '0;
            cto_q   <= '0;
            cts_q   <= '0;
            done_q  <= 1'b0;
`ifdef PATSCAN_SYNC_RD_EN
            ld_ph_q <= 1'b0;
            vld_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            prev_q  <= prev_d;
            idx_q   <= idx_d;
            ctb_q   <= ctb_d;
            cto_q   <= cto_d;
            cts_q   <= cts_d;
            done_q  <= done_d;
`ifdef PATSCAN_SYNC_RD_EN
            ld_ph_q <= ld_ph_d;
            vld_q   <= vld_d;
`endif
        end
    end

endmodule
